// File: rtl/router_pkg.sv
// Shared definitions for the router output-channel packet FIFO:
// header field defaults, read-side FSM states and the occupancy-width helper.
package router_pkg;

    localparam int unsigned LEN_MSB_DEF = 7;
    localparam int unsigned LEN_LSB_DEF = 2;

    typedef enum logic {IDLE, BODY} rd_state_e;

    // The count needs one extra bit so that DEPTH itself is representable.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage for the packet FIFO: one synchronous write port,
// one synchronous read port and no reset.
module router_fifo_mem #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output channel. Header bytes are tagged on
// entry; the read side counts payload bytes and pulses pkt_done on the parity byte.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    parameter int unsigned LEN_MSB   = LEN_MSB_DEF,
    parameter int unsigned LEN_LSB   = LEN_LSB_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   soft_reset,
    input  logic                   write_enb,
    input  logic                   lfd_state,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   read_enb,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_valid,
    output logic                   pkt_done,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = occ_width(DEPTH);
    localparam int unsigned BW = LEN_MSB - LEN_LSB + 2;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_TH);

    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            dv_q, live_q, ovf_q, unf_q;
    logic            wr_acc, rd_acc, flush;
    logic [DATA_W:0] rd_word;
    logic            rd_hdr;
    logic [BW-2:0]   rd_len;
    rd_state_e       state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;

    assign flush  = !resetn || soft_reset;
    assign wr_acc = write_enb && !full;
    assign rd_acc = read_enb && !empty;

    router_fifo_mem #(
        .WIDTH(DATA_W + 1),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc && !flush),
        .waddr(wr_ptr_q),
        .wdata({lfd_state, data_in}),
        .re   (rd_acc && !flush),
        .raddr(rd_ptr_q),
        .rdata(rd_word)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dv_q     <= 1'b0;
            live_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            dv_q <= rd_acc;
            if (rd_acc) live_q <= 1'b1;
            if (write_enb && full) ovf_q <= 1'b1;
            if (read_enb && empty) unf_q <= 1'b1;
        end
    end

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_valid   = dv_q;
    // Memory output register holds between reads; mask it until the first read after a flush.
    assign data_out     = live_q ? rd_word[DATA_W-1:0] : '0;

    assign rd_hdr = rd_word[DATA_W];
    assign rd_len = rd_word[LEN_MSB:LEN_LSB];

    // The FSM consumes the word in the cycle it is presented, since the RAM read is registered.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        if (dv_q) begin
            if (rd_hdr) begin
                state_d = BODY;
                bcnt_d  = {1'b0, rd_len} + BW'(1);
            end else if (state_q == BODY) begin
                if (bcnt_q == BW'(1)) state_d = IDLE;
                bcnt_d = bcnt_q - BW'(1);
            end
        end
    end

    always_comb begin
        pkt_done = dv_q && (state_q == BODY) && !rd_hdr && (bcnt_q == BW'(1));
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: a default 8x16 instance and a 16x64 instance,
// scoreboard of expected bytes plus a table of vectors for the basic packet sequence.
module tb_router_pkt_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic       a_sr, a_we, a_lfd, a_re;
    logic [7:0] a_din, a_dout;
    logic       a_dv, a_done, a_emp, a_ful, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_cnt;

    logic        b_sr, b_we, b_lfd, b_re;
    logic [15:0] b_din, b_dout;
    logic        b_dv, b_done, b_emp, b_ful, b_af, b_ae, b_ovf, b_unf;
    logic [6:0]  b_cnt;

    router_pkt_fifo u_a (
        .clk(clk), .resetn(resetn), .soft_reset(a_sr), .write_enb(a_we), .lfd_state(a_lfd),
        .data_in(a_din), .read_enb(a_re), .data_out(a_dout), .data_valid(a_dv),
        .pkt_done(a_done), .empty(a_emp), .full(a_ful), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
    );

    router_pkt_fifo #(
        .DATA_W(16), .DEPTH(64), .LEN_MSB(9), .LEN_LSB(2)
    ) u_b (
        .clk(clk), .resetn(resetn), .soft_reset(b_sr), .write_enb(b_we), .lfd_state(b_lfd),
        .data_in(b_din), .read_enb(b_re), .data_out(b_dout), .data_valid(b_dv),
        .pkt_done(b_done), .empty(b_emp), .full(b_ful), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
    );

    typedef struct {
        logic [15:0] d;
        bit          dn;
    } exp_t;

    exp_t   sb_a[$];
    exp_t   sb_b[$];
    bit [1:0] ovf_m, unf_m;
    int     n_chk = 0;
    int     n_fail = 0;

    typedef struct {
        bit         sr, we, lfd;
        logic [7:0] din;
        bit         dn, re;
        logic [7:0] x_dout;
        bit         x_dv, x_done, x_unf;
        int         x_cnt;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_sr = 1'b0; a_we = 1'b0; a_lfd = 1'b0; a_re = 1'b0;
        b_sr = 1'b0; b_we = 1'b0; b_lfd = 1'b0; b_re = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        sb_a.delete();
        sb_b.delete();
        ovf_m = '0;
        unf_m = '0;
    endtask

    // One clock cycle on the selected instance, with scoreboard and flag checks after the edge.
    task automatic cyc(input bit sel, input bit sr, input bit we, input bit lfd,
                       input logic [15:0] din, input bit dn, input bit re);
        int          depth, size, cnt;
        bit          wacc, racc;
        exp_t        e, w;
        logic [15:0] dout;
        logic        dv, done, emp, ful, af, ae, ovf, unf;
        string       p;
        p     = sel ? "b" : "a";
        depth = sel ? 64 : 16;
        size  = sel ? sb_b.size() : sb_a.size();
        wacc  = !sr && we && (size < depth);
        racc  = !sr && re && (size > 0);
        if (sel) begin
            b_sr = sr; b_we = we; b_lfd = lfd; b_din = din; b_re = re;
        end else begin
            a_sr = sr; a_we = we; a_lfd = lfd; a_din = din[7:0]; a_re = re;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        e.d  = '0;
        e.dn = 1'b0;
        if (sr) begin
            if (sel) sb_b.delete(); else sb_a.delete();
            ovf_m[sel] = 1'b0;
            unf_m[sel] = 1'b0;
        end else begin
            if (we && size == depth) ovf_m[sel] = 1'b1;
            if (re && size == 0) unf_m[sel] = 1'b1;
            if (racc) begin
                if (sel) e = sb_b.pop_front(); else e = sb_a.pop_front();
            end
            if (wacc) begin
                w.d  = sel ? din : {8'h00, din[7:0]};
                w.dn = dn;
                if (sel) sb_b.push_back(w); else sb_a.push_back(w);
            end
        end
        size = sel ? sb_b.size() : sb_a.size();
        if (sel) begin
            dout = b_dout; dv = b_dv; done = b_done; emp = b_emp; ful = b_ful;
            af = b_af; ae = b_ae; ovf = b_ovf; unf = b_unf; cnt = int'(b_cnt);
        end else begin
            dout = {8'h00, a_dout}; dv = a_dv; done = a_done; emp = a_emp; ful = a_ful;
            af = a_af; ae = a_ae; ovf = a_ovf; unf = a_unf; cnt = int'(a_cnt);
        end
        check({p, ".data_valid"}, dv, racc);
        if (racc) begin
            check({p, ".data_out"}, dout, e.d);
            check({p, ".pkt_done"}, done, e.dn);
        end else begin
            check({p, ".pkt_done_idle"}, done, 1'b0);
        end
        check({p, ".count"}, cnt, size);
        check({p, ".empty"}, emp, size == 0);
        check({p, ".full"}, ful, size == depth);
        check({p, ".almost_full"}, af, size >= depth - 2);
        check({p, ".almost_empty"}, ae, size <= 2);
        check({p, ".overflow"}, ovf, ovf_m[sel]);
        check({p, ".underflow"}, unf, unf_m[sel]);
    endtask

    initial begin
        a_din = '0;
        b_din = '0;
        idle_inputs();
        resetn = 1'b0;

        // Packet with length 3, readback, underflow on empty read, then soft reset.
        vt[0]  = '{0, 1, 1, 8'h0C, 0, 0, 8'h00, 0, 0, 0, 1};
        vt[1]  = '{0, 1, 0, 8'h11, 0, 0, 8'h00, 0, 0, 0, 2};
        vt[2]  = '{0, 1, 0, 8'h22, 0, 0, 8'h00, 0, 0, 0, 3};
        vt[3]  = '{0, 1, 0, 8'h33, 0, 0, 8'h00, 0, 0, 0, 4};
        vt[4]  = '{0, 1, 0, 8'h44, 1, 0, 8'h00, 0, 0, 0, 5};
        vt[5]  = '{0, 0, 0, 8'h00, 0, 1, 8'h0C, 1, 0, 0, 4};
        vt[6]  = '{0, 0, 0, 8'h00, 0, 1, 8'h11, 1, 0, 0, 3};
        vt[7]  = '{0, 0, 0, 8'h00, 0, 1, 8'h22, 1, 0, 0, 2};
        vt[8]  = '{0, 0, 0, 8'h00, 0, 1, 8'h33, 1, 0, 0, 1};
        vt[9]  = '{0, 0, 0, 8'h00, 0, 1, 8'h44, 1, 1, 0, 0};
        vt[10] = '{0, 0, 0, 8'h00, 0, 1, 8'h44, 0, 0, 1, 0};
        vt[11] = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};

        do_reset();
        check("a.reset_count", a_cnt, 5'd0);
        check("a.reset_empty", a_emp, 1'b1);
        check("a.reset_data_out", a_dout, 8'h00);
        check("a.reset_dv", a_dv, 1'b0);
        check("a.reset_sticky", {a_ovf, a_unf}, 2'b00);
        check("b.reset_count", b_cnt, 7'd0);

        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, vt[i].sr, vt[i].we, vt[i].lfd, {8'h00, vt[i].din}, vt[i].dn, vt[i].re);
            check($sformatf("vec%0d.data_out", i), a_dout, vt[i].x_dout);
            check($sformatf("vec%0d.data_valid", i), a_dv, vt[i].x_dv);
            check($sformatf("vec%0d.pkt_done", i), a_done, vt[i].x_done);
            check($sformatf("vec%0d.underflow", i), a_unf, vt[i].x_unf);
            check($sformatf("vec%0d.count", i), a_cnt, vt[i].x_cnt);
            check($sformatf("vec%0d.empty", i), a_emp, vt[i].x_cnt == 0);
        end

        // Fill to full across the pointer wrap, overflow, drain in order.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'(8'hA0 + i), 1'b0, 1'b0);
            if (i == 12) check("a.afull_13", a_af, 1'b0);
            if (i == 13) check("a.afull_14", a_af, 1'b1);
        end
        check("a.full_16", a_ful, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h00EE, 1'b0, 1'b0);
        check("a.overflow_17th", a_ovf, 1'b1);
        check("a.count_17th", a_cnt, 5'd16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check("a.empty_drained", a_emp, 1'b1);

        // Simultaneous write+read at count 8, then at full.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'(8'hB0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'(8'hC0 + i), 1'b0, 1'b1);
        check("a.count_steady_8", a_cnt, 5'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'(8'hD0 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b1);
        check("a.count_full_wr_rd", a_cnt, 5'd15);
        check("a.overflow_full_wr_rd", a_ovf, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Soft reset mid-packet, with the FSM one byte away from pkt_done.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'(8'h61 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check("a.count_mid_pkt", a_cnt, 5'd6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0077, 1'b0, 1'b0);
        check("a.count_after_flush", a_cnt, 5'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0055, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0008, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Zero-length header, then a packet truncated by a new header.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h007E, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0021, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0022, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Wide/deep instance: packet sequence, then fill/overflow/drain across the wrap.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check("b.pkt_done_parity", b_done, 1'b1);
        check("b.parity_data", b_dout, 16'h4444);
        check("b.empty_after_pkt", b_emp, 1'b1);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h1000 + i), 1'b0, 1'b0);
            if (i == 60) check("b.afull_61", b_af, 1'b0);
            if (i == 61) check("b.afull_62", b_af, 1'b1);
        end
        check("b.full_64", b_ful, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        check("b.overflow_65th", b_ovf, 1'b1);
        for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check("b.empty_drained", b_emp, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
